gf32_mul_share_arb: RTL and testbench
=====================================

Name: gf32_mul_share_arb

Overview:
- Responder side of the shared GF(2^32) multiplier interface: start/x/y in, result/done out.
- Arbitrates up to N_CLIENTS requesters (r^i units, polynomial evaluators) onto one pipelined gf_mul_32 or gf251_mul_32 instance.
- Routes each result back only to the client that issued it.
- Sits at the top of the MPC/hint path so that the multiplier-sharing option replaces per-unit multipliers.

Parameters:
- FIELD, "GF256", selects the multiplier instance: "GF256" gives gf_mul_32, anything else gives gf251_mul_32.
- N_CLIENTS, 3, number of client ports (2..8).
- TAG_DEPTH, 16, in-flight tag FIFO depth; must be at least the multiplier latency plus 1.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_req  in  N_CLIENTS  per-client session request, level; held high for the whole session
- o_gnt  out  N_CLIENTS  one-hot session grant, registered
- i_start  in  N_CLIENTS  per-client multiply start pulse
- i_x  in  32*N_CLIENTS  operand x; client k uses bits [32k+31:32k]
- i_y  in  32*N_CLIENTS  operand y; same slicing as i_x
- o_o  out  32  multiplier result, broadcast to all clients
- o_done  out  N_CLIENTS  one-hot done, qualifies o_o for the owning client
- o_busy  out  1  tag FIFO non-empty (operations in flight)
- o_err  out  1  sticky protocol-error flag

Behaviour:
- Reset values: o_gnt=0, o_done=0, o_err=0, o_busy=0; tag FIFO empty; round-robin pointer=0; FSM=IDLE.
- FSM states: IDLE, GRANT.
  - IDLE: if any i_req bit is set, grant the first requester found at or after the round-robin pointer. o_gnt is asserted the next cycle; go to GRANT.
  - GRANT: hold the grant while i_req[owner] is high.
  - GRANT, i_req[owner] falls: o_gnt goes to 0 next cycle, pointer becomes owner+1 (mod N_CLIENTS), go to IDLE.
  - Minimum gap between two sessions: 1 idle cycle.
- Issue path, combinational:
  - Multiplier start = i_start[owner] & o_gnt[owner].
  - Multiplier x/y = owner slice of i_x/i_y.
  - On an issue, push the owner index into the tag FIFO in the same cycle.
  - Back-to-back issues every cycle are allowed (pipelined multiplier).
- Return path, combinational:
  - o_o = multiplier output.
  - When multiplier done and FIFO non-empty: o_done[head tag]=1 and pop the FIFO in that cycle.
  - The start-to-done latency seen by the client equals the multiplier's native latency; the arbiter adds zero cycles.
- A grant may move to another client while results are still in flight. Those results still return to the original issuer in issue order.
- Simultaneous push and pop in one cycle: occupancy is unchanged.
- Full FIFO: issue is still forwarded to the multiplier and o_err is set; the tag is dropped.
- Other o_err sources:
  - i_start[k] asserted with o_gnt[k]=0: the start is ignored, nothing is issued.
  - Multiplier done while the FIFO is empty: the result is discarded.
- o_err clears only on reset.
- Reset mid-operation: FIFO cleared, grant dropped.
  - Late multiplier done pulses arriving after reset hit the empty-FIFO case: discarded, no o_done. This case does not set o_err for the first TAG_DEPTH cycles after reset.
- o_busy = FIFO non-empty.

Decomposition:
- Shared package: N_CLIENTS_MAX=8; TAG_W=clog2(N_CLIENTS); state encodings ST_IDLE=0, ST_GRANT=1.
- Sub-module tag_fifo: synchronous FIFO, width TAG_W, depth TAG_DEPTH, outputs full/empty.
- The multiplier is the existing gf_mul_32 / gf251_mul_32, instantiated inside a generate block on FIELD.

Test Plan:
- Single client: i_req[0]=1, gnt at +1; start x=0x00000001, y=0xA5A5A5A5 -> o_done[0] after the native latency with o_o=0xA5A5A5A5; o_done[1], o_done[2] stay 0.
- Back-to-back: client 1 issues 3 consecutive starts with x=1, y=0x11,0x22,0x33 -> three consecutive o_done[1] pulses carrying 0x11, 0x22, 0x33 in order.
- Handover in flight: client 0 issues y=0x5 (x=1), drops i_req the next cycle; client 2 is granted and issues y=0x7 -> o_done[0] with 0x5, then o_done[2] with 0x7.
- Round robin: all i_req high at once -> grant order 0,1,2,0 across sessions, each separated by 1 idle cycle.
- Protocol error: client 1 pulses i_start without a grant, x=0, y=0xFF -> no multiplier start, no o_done, o_err=1 and remains 1 until i_rst.
- Reset mid-flight: i_rst asserted one cycle after an issue -> no o_done for that operation, o_busy=0, o_err=0.

Source files
------------

// File: rtl/gf32_mul_share_arb_pkg.sv
// Shared definitions for the GF(2^32) multiplier-sharing arbiter.
//   N_CLIENTS_MAX : largest supported number of client ports
//   MUL_LAT       : native start-to-done latency of the shared multipliers
//   state_e       : session FSM encoding (ST_IDLE=0, ST_GRANT=1)
//   tag_w()       : tag width for a given client count, clog2(n), at least 1
package gf32_mul_share_arb_pkg;

  localparam int N_CLIENTS_MAX = 8;
  localparam int MUL_LAT       = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gf32_mul_share_arb_mul.sv
// Shared pipelined multipliers, both with a two-cycle start-to-done latency.
//   gf_mul_32    : GF(2^32) product modulo x^32 + x^7 + x^3 + x^2 + 1
//   gf251_mul_32 : four independent byte lanes, each (a*b) mod 251
// Ports: i_clk, i_rst (sync, active-high, clears valids only), i_start,
//        i_x, i_y operands, o_o result, o_done result strobe.
module gf_mul_32 (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  output logic [31:0] o_o,
  output logic        o_done
);

  localparam logic [31:0] POLY = 32'h0000_008D;

  logic [31:0] prod_p0, prod_p1;
  logic        vld_p0, vld_p1;

  function automatic logic [31:0] gf_mul(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] acc;
    logic [31:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[30:0], 1'b0} ^ (sh[31] ? POLY : 32'h0);
    end
    return acc;
  endfunction

  // Stage p0: full product
  always_ff @(posedge i_clk) begin
    prod_p0 <= gf_mul(i_x, i_y);
    prod_p1 <= prod_p0;
  end

  // Stage p1: output register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= i_start;
      vld_p1 <= vld_p0;
    end
  end

  assign o_o    = prod_p1;
  assign o_done = vld_p1;

endmodule

module gf251_mul_32 (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  output logic [31:0] o_o,
  output logic        o_done
);

  logic [31:0] prod_p0, prod_p1;
  logic        vld_p0, vld_p1;

  function automatic logic [31:0] lane_mul(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [15:0] p;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      p = (16'(a[8*i +: 8]) * 16'(b[8*i +: 8])) % 16'd251;
      r[8*i +: 8] = p[7:0];
    end
    return r;
  endfunction

  // Stage p0: lane products
  always_ff @(posedge i_clk) begin
    prod_p0 <= lane_mul(i_x, i_y);
    prod_p1 <= prod_p0;
  end

  // Stage p1: output register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= i_start;
      vld_p1 <= vld_p0;
    end
  end

  assign o_o    = prod_p1;
  assign o_done = vld_p1;

endmodule

// File: rtl/gf32_mul_share_arb_tag_fifo.sv
// tag_fifo: synchronous FIFO holding the issuing client index of every
// multiply in flight, so results can be steered back in issue order.
// Ports: i_clk, i_rst (sync, active-high), i_push/i_din write side,
//        i_pop/o_dout read side (o_dout is the current head), o_full, o_empty.
// Push while full and pop while empty are ignored.
module tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign o_full  = (cnt_q == CW'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_dout  = mem_q[rd_ptr_q];
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Explicit wrap so non-power-of-two depths work.
    if (do_push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Tag storage carries no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_din;
  end

endmodule

// File: rtl/gf32_mul_share_arb.sv
// gf32_mul_share_arb: grants one client at a time a session on a single
// shared pipelined multiplier and steers every result back to the client
// that issued it, in issue order, even after the grant has moved on.
// Ports: i_clk, i_rst (sync, active-high)
//        i_req/o_gnt      : level session request / registered one-hot grant
//        i_start,i_x,i_y  : per-client start pulse and 32-bit operand slices
//        o_o/o_done       : broadcast result, one-hot owner strobe
//        o_busy           : operations in flight; o_err: sticky protocol error
module gf32_mul_share_arb
  import gf32_mul_share_arb_pkg::*;
#(
  parameter string FIELD     = "GF256",
  parameter int    N_CLIENTS = 3,
  parameter int    TAG_DEPTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_CLIENTS-1:0]    i_req,
  output logic [N_CLIENTS-1:0]    o_gnt,
  input  logic [N_CLIENTS-1:0]    i_start,
  input  logic [32*N_CLIENTS-1:0] i_x,
  input  logic [32*N_CLIENTS-1:0] i_y,
  output logic [31:0]             o_o,
  output logic [N_CLIENTS-1:0]    o_done,
  output logic                    o_busy,
  output logic                    o_err
);

  localparam int TAG_W = tag_w(N_CLIENTS);
  localparam int QW    = $clog2(TAG_DEPTH + 1);

  state_e               state_q, state_d;
  logic [TAG_W-1:0]     owner_q, owner_d;
  logic [TAG_W-1:0]     ptr_q, ptr_d;
  logic [N_CLIENTS-1:0] gnt_q, gnt_d;
  logic                 err_q, err_d;
  logic [QW-1:0]        quiet_q, quiet_d;

  logic                 mul_start, mul_done;
  logic [31:0]          mul_x, mul_y, mul_o;
  logic                 fifo_full, fifo_empty, push, pop;
  logic [TAG_W-1:0]     head;
  logic                 stray, dropped, orphan;
  int                   idx;
  logic                 found;

  // Session FSM: round-robin search from ptr_q while idle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx     = 0;
    found   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        for (int i = 0; i < N_CLIENTS; i++) begin
          idx = (int'(ptr_q) + i) % N_CLIENTS;
          if (!found && i_req[idx]) begin
            found      = 1'b1;
            owner_d    = TAG_W'(idx);
            gnt_d      = '0;
            gnt_d[idx] = 1'b1;
            state_d    = ST_GRANT;
          end
        end
      end
      ST_GRANT: begin
        if (!i_req[owner_q]) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
          ptr_d   = (owner_q == TAG_W'(N_CLIENTS - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Issue and return paths are purely combinational so the client sees the
  // multiplier's native latency.
  always_comb begin
    mul_start = i_start[owner_q] & gnt_q[owner_q];
    mul_x     = i_x[32*owner_q +: 32];
    mul_y     = i_y[32*owner_q +: 32];
    push      = mul_start & ~fifo_full;
    dropped   = mul_start & fifo_full;
    stray     = |(i_start & ~gnt_q);
    pop       = mul_done & ~fifo_empty;
    // Done pulses still draining from before a reset land on an empty FIFO;
    // they are only reported once the post-reset quiet window has expired.
    orphan    = mul_done & fifo_empty & (quiet_q == '0);
    o_done    = '0;
    if (pop) o_done[head] = 1'b1;
    err_d     = err_q | stray | dropped | orphan;
    quiet_d   = (quiet_q != '0) ? quiet_q - 1'b1 : quiet_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      err_q   <= 1'b0;
      quiet_q <= QW'(TAG_DEPTH);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      quiet_q <= quiet_d;
    end
  end

  tag_fifo #(.W(TAG_W), .DEPTH(TAG_DEPTH)) u_tag_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (push),
    .i_din  (owner_q),
    .i_pop  (pop),
    .o_dout (head),
    .o_full (fifo_full),
    .o_empty(fifo_empty)
  );

  if (FIELD == "GF256") begin : g_gf256
    gf_mul_32 u_mul (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(mul_start),
      .i_x(mul_x), .i_y(mul_y), .o_o(mul_o), .o_done(mul_done)
    );
  end else begin : g_gf251
    gf251_mul_32 u_mul (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(mul_start),
      .i_x(mul_x), .i_y(mul_y), .o_o(mul_o), .o_done(mul_done)
    );
  end

  assign o_gnt  = gnt_q;
  assign o_err  = err_q;
  assign o_busy = ~fifo_empty;
  assign o_o    = mul_o;

endmodule

// File: tb/tb_gf32_mul_share_arb.sv
// Bench for gf32_mul_share_arb (GF256 field, three clients).
module tb_gf32_mul_share_arb;

  localparam int NC = 3;

  logic          i_clk;
  logic          i_rst;
  logic [NC-1:0] i_req;
  logic [NC-1:0] o_gnt;
  logic [NC-1:0] i_start;
  logic [32*NC-1:0] i_x;
  logic [32*NC-1:0] i_y;
  logic [31:0]   o_o;
  logic [NC-1:0] o_done;
  logic          o_busy;
  logic          o_err;

  gf32_mul_share_arb #(.FIELD("GF256"), .N_CLIENTS(NC), .TAG_DEPTH(16)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_req  (i_req),
    .o_gnt  (o_gnt),
    .i_start(i_start),
    .i_x    (i_x),
    .i_y    (i_y),
    .o_o    (o_o),
    .o_done (o_done),
    .o_busy (o_busy),
    .o_err  (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          cl;
    logic [31:0] val;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          cl;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every o_done must match the oldest outstanding issue in
  // owner, value and arrival cycle (issue cycle + 2).
  always @(negedge i_clk) begin
    if (o_done != '0) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=%b required=000 (t=%0t)", o_done, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_vec", 32'(o_done), 32'(1 << e.cl));
        chk("done_val", o_o, e.val);
        chk("done_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cyc_next();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst   = 1'b1;
    i_req   = '0;
    i_start = '0;
    cyc_next();
    cyc_next();
    i_rst = 1'b0;
  endtask

  task automatic open_session(input int k);
    logic ok;
    ok = 1'b0;
    i_req[k] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cyc_next();
      if (o_gnt[k]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("gnt_wait", 32'(ok), 32'd1);
  endtask

  task automatic close_session(input int k);
    i_req[k] = 1'b0;
    cyc_next();
    cyc_next();
    chk("gnt_drop", 32'(o_gnt), 32'd0);
  endtask

  task automatic issue(input int k, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input bit track);
    exp_t e;
    i_start[k]      = 1'b1;
    i_x[32*k +: 32] = x;
    i_y[32*k +: 32] = y;
    if (track) begin
      e.cl  = k;
      e.val = exp;
      e.cyc = cyc + 2;
      sb.push_back(e);
    end
    cyc_next();
    i_start[k] = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 40; c++) begin
      if (sb.size() == 0) break;
      cyc_next();
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    tbl[0] = '{cl: 0, x: 32'h0000_0002, y: 32'h8000_0000, exp: 32'h0000_008D};
    tbl[1] = '{cl: 1, x: 32'h0000_0002, y: 32'h4000_0000, exp: 32'h8000_0000};
    tbl[2] = '{cl: 2, x: 32'h0000_0003, y: 32'h8000_0001, exp: 32'h8000_008E};
    tbl[3] = '{cl: 0, x: 32'h0000_0100, y: 32'h0100_0000, exp: 32'h0000_008D};
    tbl[4] = '{cl: 1, x: 32'hDEAD_BEEF, y: 32'h0000_0001, exp: 32'hDEAD_BEEF};
    tbl[5] = '{cl: 2, x: 32'hFFFF_FFFF, y: 32'h0000_0000, exp: 32'h0000_0000};
    tbl[6] = '{cl: 0, x: 32'h0001_0000, y: 32'h0001_0000, exp: 32'h0000_008D};
    tbl[7] = '{cl: 2, x: 32'h0000_0005, y: 32'h0000_0003, exp: 32'h0000_000F};

    i_rst   = 1'b1;
    i_req   = '0;
    i_start = '0;
    i_x     = '0;
    i_y     = '0;
    @(negedge i_clk);
    cyc_next();
    cyc_next();
    i_rst = 1'b0;
    chk("rst_gnt",  32'(o_gnt),  32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_err",  32'(o_err),  32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);

    // Single client, grant exactly one cycle after the request.
    i_req[0] = 1'b1;
    cyc_next();
    chk("single_gnt", 32'(o_gnt), 32'b001);
    issue(0, 32'h0000_0001, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1);
    chk("single_busy", 32'(o_busy), 32'd1);
    close_session(0);
    drain();

    // Back-to-back issues from client 1.
    open_session(1);
    issue(1, 32'h1, 32'h11, 32'h11, 1'b1);
    issue(1, 32'h1, 32'h22, 32'h22, 1'b1);
    chk("b2b_busy", 32'(o_busy), 32'd1);
    issue(1, 32'h1, 32'h33, 32'h33, 1'b1);
    close_session(1);
    drain();
    chk("b2b_idle_busy", 32'(o_busy), 32'd0);

    // Table-driven vectors, one session each.
    for (int i = 0; i < 8; i++) begin
      open_session(tbl[i].cl);
      issue(tbl[i].cl, tbl[i].x, tbl[i].y, tbl[i].exp, 1'b1);
      close_session(tbl[i].cl);
    end
    drain();

    // Handover while client 0's result is still in flight.
    open_session(0);
    issue(0, 32'h1, 32'h5, 32'h5, 1'b1);
    i_req[0] = 1'b0;
    i_req[2] = 1'b1;
    open_session(2);
    issue(2, 32'h1, 32'h7, 32'h7, 1'b1);
    close_session(2);
    drain();
    chk("handover_err", 32'(o_err), 32'd0);

    // Round robin with all clients requesting; pointer starts at 0.
    do_reset();
    i_req = 3'b111;
    cyc_next();
    chk("rr_first", 32'(o_gnt), 32'b001);
    for (int s = 1; s <= 3; s++) begin
      int prev;
      int nxt;
      prev = s - 1;
      nxt  = s % 3;
      i_req[prev] = 1'b0;
      cyc_next();
      chk("rr_gap", 32'(o_gnt), 32'b000);
      i_req[prev] = 1'b1;
      cyc_next();
      chk("rr_next", 32'(o_gnt), 32'(1 << nxt));
    end
    i_req = '0;
    cyc_next();
    cyc_next();
    chk("rr_end", 32'(o_gnt), 32'b000);

    // Start without a grant: ignored, error is sticky until reset.
    chk("perr_pre", 32'(o_err), 32'd0);
    issue(1, 32'h0, 32'hFF, 32'h0, 1'b0);
    chk("perr_set",  32'(o_err),  32'd1);
    chk("perr_busy", 32'(o_busy), 32'd0);
    for (int c = 0; c < 4; c++) cyc_next();
    chk("perr_sticky", 32'(o_err), 32'd1);
    do_reset();
    chk("perr_clear", 32'(o_err), 32'd0);

    // Reset one cycle after an issue: the operation never completes.
    open_session(0);
    issue(0, 32'h1, 32'h1234, 32'h1234, 1'b0);
    chk("mid_busy", 32'(o_busy), 32'd1);
    do_reset();
    chk("mid_busy_clr", 32'(o_busy), 32'd0);
    chk("mid_gnt_clr",  32'(o_gnt),  32'd0);
    for (int c = 0; c < 5; c++) cyc_next();
    chk("mid_err",  32'(o_err),  32'd0);
    chk("mid_busy_late", 32'(o_busy), 32'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
